hex_display_scanner: RTL
========================

# hex_display_scanner

Time-multiplexed scan controller for a bank of common-segment 7-segment digits. Holds one hex nibble per digit and a decimal-point mask, and steps through the digits at a programmable refresh rate. For each slot it presents the current nibble to the downstream hex-to-7-segment decoder together with a one-hot digit select. New display values are double-buffered and take effect only at a frame boundary, so a frame never shows mixed old and new values.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 1000, clock cycles each digit stays selected (>=2)
- clk  input  1  single clock; all logic is on the rising edge
- rst_n  input  1  synchronous, active-low reset
- load_valid  input  1  producer offers a new display word
- load_ready  output  1  pending buffer empty; the word is accepted on valid&&ready
- load_data  input  4*NUM_DIGITS  nibble k in bits [4k+3:4k]; digit 0 is the least significant
- load_dp  input  NUM_DIGITS  decimal-point enable per digit
- digit_hex  output  4  nibble for the decoder
- digit_dp  output  1  decimal point for the current digit
- digit_sel  output  NUM_DIGITS  one-hot, active-high digit enable
- blank  output  1  current slot is blanked (digit_sel is all zero)
- frame_start  output  1  one-cycle pulse when digit 0 becomes selected

## Operation
- Prescaler counts 0..REFRESH_DIV-1. The cycle at REFRESH_DIV-1 is the terminal tick.
- Digit index idx advances on each tick: idx+1, wrapping from NUM_DIGITS-1 to 0.
- The wrap to 0 is the frame boundary. At that edge:
  - the pending buffer, if full, copies into the active registers;
  - pending is marked empty.
- Outputs are registered from the active registers:
  - digit_hex = active nibble[idx]
  - digit_dp = active_dp[idx]
  - digit_sel = one-hot(idx)
- Load handshake:
  - load_ready = !pending_full.
  - On valid&&ready, load_data and load_dp are captured into pending, and pending_full is set.
  - The producer must hold the word stable while valid is high and ready is low.
- Simultaneous accept and frame boundary: this cannot occur with a full buffer, because ready is low. If pending is empty at the boundary, the active registers are unchanged and the accepted word waits for the next boundary.
- A newer word can never overwrite pending before it has been transferred.
- Reset mid-frame: all state clears on the next edge with rst_n=0.

## Timing
- Reset values, all valid in the cycle after the reset edge:
  - prescaler=0, idx=0, active=0, pending empty
  - load_ready=1, digit_hex=0, digit_dp=0, digit_sel=0, blank=0, frame_start=0
- First release cycle: digit_sel=1 (digit 0 selected) and frame_start=1 on the first edge with rst_n=1.
- Each digit is held for exactly REFRESH_DIV cycles. A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- frame_start is high for exactly one cycle per frame, aligned with digit_sel becoming 1.
- Load-to-display latency: from acceptance until the next frame boundary, at most NUM_DIGITS*REFRESH_DIV cycles plus 1. New values first appear together with frame_start.
- load_ready rises in the cycle after the boundary transfer.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant non-zero active nibble are blanked: digit_sel=0 and blank=1 for that slot.
  - Digit 0 is never blanked.
  - A digit whose dp bit is set is never blanked.
  - The blank decision uses the active registers of the current frame.
- LEADING_ZERO_BLANK_EN undefined: every digit is shown and blank is tied to 0.

## Structure
- Package hex_display_pkg holds:
  - the default NUM_DIGITS and REFRESH_DIV constants;
  - a digit-index width constant/function, clog2 of NUM_DIGITS;
  - the nibble typedef.
- One sub-module, hex_display_tick: a parameterised prescaler that outputs the terminal-tick pulse, with the same reset.
- Scan index, handshake and output registers stay in the top level.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- Reset then release with no load -> digit_sel steps 0001,0010,0100,1000 every 4 cycles; digit_hex=0; frame_start every 16 cycles.
- Load 16'h1A3F with dp 4'b0100 mid-frame -> accepted in 1 cycle and load_ready drops. From the next frame_start: digit_hex sequence F,3,A,1, and digit_dp=1 only while digit_sel=0100.
- Second load while pending is full -> load_ready=0 and the word is held. It is accepted in the cycle after the boundary and displayed one frame later.
- Assert rst_n=0 while digit 2 is selected -> the next cycle shows all outputs 0. On release, digit_sel=0001 and frame_start=1.
- With LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 show blank=1 and digit_sel=0; digits 1 and 0 show 5 and 0.
- With LEADING_ZERO_BLANK_EN, load 16'h0000 with dp 4'b1000 -> digits 3 and 0 are shown (value 0; digit_dp=1 on digit 3). Digits 2 and 1 are blanked.

Source files
------------

// File: rtl/hex_display_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
// Shared definitions for the hex display scanner:
//   DEFAULT_NUM_DIGITS  - default number of scanned digits
//   DEFAULT_REFRESH_DIV - default clock cycles each digit stays selected
//   idx_width()         - width of a digit index (clog2 of the digit count)
//   nibble_t            - one hex digit value
// -----------------------------------------------------------------------------
package hex_display_pkg;

    localparam int DEFAULT_NUM_DIGITS  = 4;
    localparam int DEFAULT_REFRESH_DIV = 1000;

    typedef logic [3:0] nibble_t;

    // Never returns zero so a digit index is always at least one bit wide.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_display_tick.sv
// -----------------------------------------------------------------------------
// hex_display_tick
// Prescaler counting 0..DIV-1 while enabled; tick is high during the cycle in
// which the count sits at DIV-1 (the terminal cycle).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset, clears the count to 0
//   en     - count enable; tick is suppressed while low
//   tick   - terminal-count pulse
// -----------------------------------------------------------------------------
module hex_display_tick #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    assign tick = en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
// Time-multiplexed scan controller for a bank of 7-segment digits. Holds one
// nibble and one decimal point per digit, steps a one-hot digit select every
// REFRESH_DIV cycles, and swaps in newly loaded values only at frame
// boundaries (double-buffered through a single pending word).
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the
// most significant non-zero nibble (digit 0 and dp-marked digits stay lit).
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset
//   load_valid   - producer offers a display word
//   load_ready   - pending buffer empty; word accepted on valid && ready
//   load_data    - nibble k in bits [4k+3:4k], digit 0 least significant
//   load_dp      - decimal-point enable per digit
//   digit_hex    - nibble of the selected digit
//   digit_dp     - decimal point of the selected digit
//   digit_sel    - one-hot active-high digit enable (zero when blanked)
//   blank        - current slot is blanked
//   frame_start  - one-cycle pulse when digit 0 becomes selected
// -----------------------------------------------------------------------------
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [3:0]              digit_hex,
    output logic                    digit_dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    blank,
    output logic                    frame_start
);

    localparam int                    IDX_W    = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    // Scan state
    logic             started_q, started_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Display buffers
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   pending_dp_q, pending_dp_d;
    logic                    pending_full_q, pending_full_d;

    // Output registers
    nibble_t               digit_hex_q, digit_hex_d;
    logic                  digit_dp_q, digit_dp_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  blank_q, blank_d;
    logic                  frame_start_q, frame_start_d;

    logic tick;
    logic wrap;
    logic boundary;
    logic accept;

    nibble_t               active_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_mask;

    // The prescaler is held at 0 until the first cycle out of reset has
    // registered digit 0, so digit 0 of the first frame gets its full slot.
    hex_display_tick #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (started_q),
        .tick  (tick)
    );

    assign load_ready = !pending_full_q;
    assign accept     = load_valid && load_ready;
    assign wrap       = (idx_q == LAST_IDX);
    assign boundary   = tick && wrap;

    always_comb begin : scan_next
        started_d = 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // A full pending buffer always blocks accept, so transfer-out and
    // capture-in never collide on the same word.
    always_comb begin : buffer_next
        active_d       = active_q;
        active_dp_d    = active_dp_q;
        pending_d      = pending_q;
        pending_dp_d   = pending_dp_q;
        pending_full_d = pending_full_q;
        if (boundary) begin
            if (pending_full_q) begin
                active_d    = pending_q;
                active_dp_d = pending_dp_q;
            end
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = load_data;
            pending_dp_d   = load_dp;
            pending_full_d = 1'b1;
        end
    end

    // Outputs are built from the next-state buffers so new values appear
    // in the same cycle as frame_start.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign active_nib[gi] = active_d[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_upper_zero;

    // Walk from the top digit down; a digit is blanked while every nibble
    // from it upward is zero, unless it carries a decimal point or is digit 0.
    always_comb begin : lead_zero
        lz_upper_zero = 1'b1;
        blank_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_upper_zero = lz_upper_zero && (active_nib[k] == 4'h0);
            blank_mask[k] = lz_upper_zero && !active_dp_d[k] && (k != 0);
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin : out_next
        digit_hex_d   = active_nib[idx_d];
        digit_dp_d    = active_dp_d[idx_d];
        blank_d       = blank_mask[idx_d];
        digit_sel_d   = blank_d ? '0 : (SEL_ONE << idx_d);
        // The first cycle out of reset starts a frame as well.
        frame_start_d = !started_q || boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started_q      <= 1'b0;
            idx_q          <= '0;
            active_q       <= '0;
            active_dp_q    <= '0;
            pending_q      <= '0;
            pending_dp_q   <= '0;
            pending_full_q <= 1'b0;
            digit_hex_q    <= '0;
            digit_dp_q     <= 1'b0;
            digit_sel_q    <= '0;
            blank_q        <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            started_q      <= started_d;
            idx_q          <= idx_d;
            active_q       <= active_d;
            active_dp_q    <= active_dp_d;
            pending_q      <= pending_d;
            pending_dp_q   <= pending_dp_d;
            pending_full_q <= pending_full_d;
            digit_hex_q    <= digit_hex_d;
            digit_dp_q     <= digit_dp_d;
            digit_sel_q    <= digit_sel_d;
            blank_q        <= blank_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign digit_hex   = digit_hex_q;
    assign digit_dp    = digit_dp_q;
    assign digit_sel   = digit_sel_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule
